// File: rtl/ac_stream_sequencer.sv
// Byte-stream sequencer for the Aho-Corasick matcher core: paces EN/INITIALIZE per byte,
// samples the core's match result and queues {position, id} reports for a valid/ready sink.
module ac_stream_sequencer #(
    parameter int DATA_W    = 8,
    parameter int ID_W      = 4,
    parameter int POS_W     = 16,
    parameter int MATCH_LAT = 1,
    parameter int RPT_DEPTH = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic [POS_W-1:0]  LEN,
    output logic              BUSY,
    output logic              DONE,
    input  logic              S_VALID,
    input  logic [DATA_W-1:0] S_DATA,
    output logic              S_READY,
    output logic              CORE_EN,
    output logic              CORE_INITIALIZE,
    output logic [DATA_W-1:0] CORE_STRING,
    input  logic              CORE_MATCH,
    input  logic [ID_W-1:0]   CORE_MATCH_ID,
    output logic              M_VALID,
    output logic [POS_W-1:0]  M_POS,
    output logic [ID_W-1:0]   M_ID,
    input  logic              M_READY
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_FEED  = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_INIT  = 3'd4;
    localparam logic [2:0] S_DRAIN = 3'd5;
    localparam logic [2:0] S_FIN   = 3'd6;

    localparam int AW  = $clog2(RPT_DEPTH);
    localparam int CW  = AW + 1;
    localparam int WCW = $clog2(MATCH_LAT + 1);
    localparam logic [WCW-1:0] WAIT_LAST = WCW'((MATCH_LAT > 1) ? MATCH_LAT - 2 : 0);

    logic [2:0]        state_q, state_d;
    logic [POS_W-1:0]  len_q, len_d;
    logic [POS_W-1:0]  pos_q, pos_d;
    logic [DATA_W-1:0] str_q, str_d;
    logic [WCW-1:0]    wcnt_q, wcnt_d;
    logic              busy_q, done_q, en_q, init_q;

    logic [POS_W-1:0]  pos_mem [RPT_DEPTH];
    logic [ID_W-1:0]   id_mem  [RPT_DEPTH];
    logic [AW-1:0]     wr_q, rd_q;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              push, pop;

    // Only the INIT cycle samples the core; FETCH gating guarantees a free slot here.
    assign push    = (state_q == S_INIT) && CORE_MATCH;
    assign M_VALID = (cnt_q != '0);
    assign pop     = M_VALID && M_READY;
    assign S_READY = (state_q == S_FETCH) && (cnt_q < CW'(RPT_DEPTH));
    assign cnt_d   = cnt_q + CW'(push) - CW'(pop);

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        pos_d   = pos_q;
        str_d   = str_q;
        wcnt_d  = wcnt_q;
        case (state_q)
            S_IDLE: begin
                if (START) begin
                    len_d   = LEN;
                    pos_d   = '0;
                    state_d = (LEN == '0) ? S_DRAIN : S_FETCH;
                end
            end
            S_FETCH: begin
                if (S_VALID && S_READY) begin
                    str_d   = S_DATA;
                    state_d = S_FEED;
                end
            end
            S_FEED: begin
                wcnt_d  = '0;
                state_d = (MATCH_LAT > 1) ? S_WAIT : S_INIT;
            end
            S_WAIT: begin
                if (wcnt_q == WAIT_LAST) state_d = S_INIT;
                else                     wcnt_d  = wcnt_q + WCW'(1);
            end
            S_INIT: begin
                if (pos_q == len_q - POS_W'(1)) begin
                    state_d = S_DRAIN;
                end else begin
                    pos_d   = pos_q + POS_W'(1);
                    state_d = S_FETCH;
                end
            end
            // Look at the post-edge count so a pop this cycle lets FIN follow immediately.
            S_DRAIN: if (cnt_d == '0) state_d = S_FIN;
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            pos_q   <= '0;
            str_q   <= '0;
            wcnt_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            en_q    <= 1'b0;
            init_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            pos_q   <= pos_d;
            str_q   <= str_d;
            wcnt_q  <= wcnt_d;
            busy_q  <= (state_d != S_IDLE);
            done_q  <= (state_d == S_FIN);
            en_q    <= (state_d == S_FEED);
            init_q  <= (state_d == S_INIT);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (push) wr_q <= wr_q + AW'(1);
            if (pop)  rd_q <= rd_q + AW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            pos_mem[wr_q] <= pos_q;
            id_mem[wr_q]  <= CORE_MATCH_ID;
        end
    end

    assign BUSY            = busy_q;
    assign DONE            = done_q;
    assign CORE_EN         = en_q;
    assign CORE_INITIALIZE = init_q;
    assign CORE_STRING     = str_q;
    assign M_POS           = pos_mem[rd_q];
    assign M_ID            = id_mem[rd_q];

endmodule

// File: tb/tb_ac_stream_sequencer.sv
// Scoreboard bench for ac_stream_sequencer: one instance at MATCH_LAT=1, one at MATCH_LAT=3,
// each paired with a small behavioural core model and byte source.
module tb_ac_stream_sequencer;
    localparam int DW = 8;
    localparam int IW = 4;
    localparam int PW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [PW-1:0] len = '0;
    logic          busy, done, s_ready, core_en, core_init, m_valid;
    logic          s_valid = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic [DW-1:0] core_str;
    logic          core_match;
    logic [IW-1:0] core_id;
    logic [PW-1:0] m_pos;
    logic [IW-1:0] m_id;
    logic          m_ready = 1'b0;

    logic          start3 = 1'b0;
    logic [PW-1:0] len3 = '0;
    logic          busy3, done3, sr3, en3, init3, mv3;
    logic          sv3 = 1'b0;
    logic [DW-1:0] sd3 = '0;
    logic [DW-1:0] str3;
    logic          match3;
    logic [IW-1:0] id3;
    logic [PW-1:0] mpos3;
    logic [IW-1:0] mid3;
    logic          mrdy3 = 1'b1;

    ac_stream_sequencer #(.DATA_W(DW), .ID_W(IW), .POS_W(PW), .MATCH_LAT(1), .RPT_DEPTH(4)) dut (
        .CLK(clk), .RST(rst), .START(start), .LEN(len), .BUSY(busy), .DONE(done),
        .S_VALID(s_valid), .S_DATA(s_data), .S_READY(s_ready),
        .CORE_EN(core_en), .CORE_INITIALIZE(core_init), .CORE_STRING(core_str),
        .CORE_MATCH(core_match), .CORE_MATCH_ID(core_id),
        .M_VALID(m_valid), .M_POS(m_pos), .M_ID(m_id), .M_READY(m_ready));

    ac_stream_sequencer #(.DATA_W(DW), .ID_W(IW), .POS_W(PW), .MATCH_LAT(3), .RPT_DEPTH(4)) dut3 (
        .CLK(clk), .RST(rst), .START(start3), .LEN(len3), .BUSY(busy3), .DONE(done3),
        .S_VALID(sv3), .S_DATA(sd3), .S_READY(sr3),
        .CORE_EN(en3), .CORE_INITIALIZE(init3), .CORE_STRING(str3),
        .CORE_MATCH(match3), .CORE_MATCH_ID(id3),
        .M_VALID(mv3), .M_POS(mpos3), .M_ID(mid3), .M_READY(mrdy3));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Core model, latency 1: 0x63 matches with id 5; match_all makes every byte match with id = low nibble.
    bit   match_all = 1'b0;
    logic en_c1 = 1'b0;
    always @(posedge clk) en_c1 <= core_en;
    assign core_match = en_c1 && (match_all || core_str == 8'h63);
    assign core_id    = (core_str == 8'h63) ? 4'd5 : core_str[3:0];

    // Core model, latency 3, plus a spurious match pulse (id 7) in the first WAIT cycle.
    logic [2:0] eh_c = '0;
    always @(posedge clk) eh_c <= {eh_c[1:0], en3};
    assign match3 = (eh_c[2] && str3 == 8'h63) || eh_c[0];
    assign id3    = eh_c[2] ? 4'd5 : 4'd7;

    // Byte source for dut; main owns src_*, the monitor owns xfer_tot.
    logic [DW-1:0] src_bytes [8];
    int src_n = 0, src_base = 0, src_gap = 0;
    int xfer_tot = 0;
    int last_tot = 0, gap_cnt = 0;
    always @(posedge clk) begin
        #1;
        if (xfer_tot != last_tot) begin
            last_tot = xfer_tot;
            gap_cnt  = src_gap;
        end
        if (gap_cnt > 0) begin
            s_valid = 1'b0;
            gap_cnt--;
        end else if (xfer_tot - src_base < src_n) begin
            s_valid = 1'b1;
            s_data  = src_bytes[xfer_tot - src_base];
        end else begin
            s_valid = 1'b0;
        end
    end

    logic [PW+IW-1:0] sb [$];
    int en_cnt = 0, init_cnt = 0, done_cnt = 0, sr_cnt = 0, rpt_cnt = 0;
    logic en_prev = 1'b0, rst_d = 1'b1;
    always @(negedge clk) begin
        logic [PW+IW-1:0] e;
        if (s_valid && s_ready) begin
            if (match_all || s_data == 8'h63)
                sb.push_back({PW'(xfer_tot - src_base), (s_data == 8'h63) ? 4'd5 : s_data[3:0]});
            xfer_tot++;
        end
        if (m_valid && m_ready) begin
            rpt_cnt++;
            if (sb.size() == 0) begin
                chk("sb_unexpected", 32'(m_pos), 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                chk("m_pos", 32'(m_pos), 32'(e[PW+IW-1:IW]));
                chk("m_id", 32'(m_id), 32'(e[IW-1:0]));
            end
        end
        if (en_prev && !rst && !rst_d) chk("en_then_init", 32'(core_init), 32'd1);
        if (s_ready && !s_valid) chk("gap_core_ctl", 32'({core_en, core_init}), 32'd0);
        if (core_en)   en_cnt++;
        if (core_init) init_cnt++;
        if (done)      done_cnt++;
        if (s_ready)   sr_cnt++;
        en_prev = core_en;
        rst_d   = rst;
    end

    // Source and scoreboard for dut3.
    logic [DW-1:0] b3 [2];
    int n3 = 0, x3 = 0, en3_cnt = 0, rpt3_cnt = 0;
    logic [PW+IW-1:0] sb3 [$];
    logic [2:0] enh3 = '0;
    always @(posedge clk) begin
        #1;
        sv3 = (x3 < n3);
        sd3 = (x3 < n3) ? b3[x3] : 8'h00;
    end
    always @(negedge clk) begin
        logic [PW+IW-1:0] e;
        if (sv3 && sr3) begin
            if (sd3 == 8'h63) sb3.push_back({PW'(x3), 4'd5});
            x3++;
        end
        if (mv3 && mrdy3) begin
            rpt3_cnt++;
            if (sb3.size() == 0) begin
                chk("sb3_unexpected", 32'(mid3), 32'hFFFF_FFFF);
            end else begin
                e = sb3.pop_front();
                chk("m3_pos", 32'(mpos3), 32'(e[PW+IW-1:IW]));
                chk("m3_id", 32'(mid3), 32'(e[IW-1:0]));
            end
        end
        if (init3) chk("lat3_en_gap", 32'(enh3), 32'b100);
        if (en3) en3_cnt++;
        enh3 = {enh3[1:0], en3};
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_stream(input int n, input int maxc, output int cyc);
        start = 1'b1;
        len   = PW'(n);
        tick();
        start = 1'b0;
        cyc   = 1;
        while (!done && cyc < maxc) begin
            tick();
            cyc++;
        end
        chk("done_seen", 32'(done), 32'd1);
    endtask

    task automatic load_src(input logic [DW-1:0] first, input int n);
        for (int i = 0; i < n; i++) src_bytes[i] = first + DW'(i);
        src_base = xfer_tot;
        src_n    = n;
    endtask

    initial begin
        int cyc, e0, i0, d0, s0, r0;
        b3[0] = 8'h63;
        b3[1] = 8'h41;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Reset mid-stream
        match_all = 1'b0;
        m_ready   = 1'b1;
        load_src(8'h10, 6);
        tick();
        start = 1'b1;
        len   = 16'd6;
        tick();
        start = 1'b0;
        repeat (5) tick();
        chk("pre_rst_busy", 32'(busy), 32'd1);
        d0  = done_cnt;
        rst = 1'b1;
        src_n = 0;
        tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_core", 32'({core_en, core_init}), 32'd0);
        chk("rst_str", 32'(core_str), 32'd0);
        chk("rst_mvalid", 32'(m_valid), 32'd0);
        chk("rst_sready", 32'(s_ready), 32'd0);
        tick();
        rst = 1'b0;
        repeat (3) tick();
        chk("rst_no_done", 32'(done_cnt - d0), 32'd0);

        // Basic: LEN=3, match on byte 2
        src_bytes[0] = 8'h61; src_bytes[1] = 8'h62; src_bytes[2] = 8'h63;
        src_base = xfer_tot; src_n = 3;
        e0 = en_cnt; i0 = init_cnt; d0 = done_cnt; r0 = rpt_cnt;
        tick();
        run_stream(3, 40, cyc);
        chk("basic_latency", 32'(cyc), 32'd11);
        repeat (3) tick();
        chk("basic_en", 32'(en_cnt - e0), 32'd3);
        chk("basic_init", 32'(init_cnt - i0), 32'd3);
        chk("basic_done", 32'(done_cnt - d0), 32'd1);
        chk("basic_rpts", 32'(rpt_cnt - r0), 32'd1);
        chk("basic_busy_after", 32'(busy), 32'd0);

        // Backpressure: FIFO fills after 4 bytes
        match_all = 1'b1;
        m_ready   = 1'b0;
        load_src(8'h11, 6);
        e0 = en_cnt; r0 = rpt_cnt;
        tick();
        start = 1'b1;
        len   = 16'd6;
        tick();
        start = 1'b0;
        repeat (40) tick();
        chk("bp_accepted", 32'(xfer_tot - src_base), 32'd4);
        chk("bp_sready", 32'(s_ready), 32'd0);
        chk("bp_mvalid", 32'(m_valid), 32'd1);
        chk("bp_head_pos", 32'(m_pos), 32'd0);
        chk("bp_head_id", 32'(m_id), 32'd1);
        m_ready = 1'b1;
        cyc = 0;
        while (!done && cyc < 200) begin
            tick();
            cyc++;
        end
        chk("bp_done", 32'(done), 32'd1);
        tick();
        chk("bp_en", 32'(en_cnt - e0), 32'd6);
        chk("bp_rpts", 32'(rpt_cnt - r0), 32'd6);
        chk("bp_sb_empty", 32'(sb.size()), 32'd0);

        // Empty stream
        match_all = 1'b0;
        src_n = 0;
        e0 = en_cnt; s0 = sr_cnt;
        tick();
        run_stream(0, 20, cyc);
        chk("empty_latency", 32'(cyc), 32'd2);
        tick();
        chk("empty_en", 32'(en_cnt - e0), 32'd0);
        chk("empty_sready", 32'(sr_cnt - s0), 32'd0);

        // Source gaps and an ignored re-START
        src_bytes[0] = 8'h63; src_bytes[1] = 8'h20; src_bytes[2] = 8'h63;
        src_base = xfer_tot; src_n = 3; src_gap = 5;
        e0 = en_cnt; d0 = done_cnt; r0 = rpt_cnt;
        tick();
        start = 1'b1;
        len   = 16'd3;
        tick();
        start = 1'b0;
        len   = 16'd1;
        repeat (4) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 0;
        while (!done && cyc < 100) begin
            tick();
            cyc++;
        end
        chk("gap_done", 32'(done), 32'd1);
        repeat (3) tick();
        src_gap = 0;
        chk("gap_en", 32'(en_cnt - e0), 32'd3);
        chk("gap_done_once", 32'(done_cnt - d0), 32'd1);
        chk("gap_rpts", 32'(rpt_cnt - r0), 32'd2);
        chk("gap_sb_empty", 32'(sb.size()), 32'd0);

        // MATCH_LAT=3 instance
        n3 = 2;
        tick();
        start3 = 1'b1;
        len3   = 16'd2;
        tick();
        start3 = 1'b0;
        cyc = 1;
        while (!done3 && cyc < 60) begin
            tick();
            cyc++;
        end
        chk("lat3_done", 32'(done3), 32'd1);
        chk("lat3_latency", 32'(cyc), 32'd12);
        tick();
        chk("lat3_en", 32'(en3_cnt), 32'd2);
        chk("lat3_rpts", 32'(rpt3_cnt), 32'd1);
        chk("lat3_sb_empty", 32'(sb3.size()), 32'd0);
        chk("lat3_busy_after", 32'(busy3), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
